sequenciador_uc: RTL and testbench

Parametrised control unit for the sensor/serial/servo round. One `jogar` request runs the full round:
- measure all sensors;
- wait a settling interval;
- transmit `N_SENSORS × BYTES_PER_SENSOR` bytes through the serial TX;
- receive `N_RX` command bytes, loading one destination register per byte.

Sensor, byte, receive and settle counters are internal, so the datapath only supplies handshakes. It sits between the top-level game FSM and the sensor/serial/servo datapath, replacing the fixed-count control unit.

---
 rtl/sequenciador_uc.sv | 174 +++++++++++++++++
 tb/tb_sequenciador_uc.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/sequenciador_uc.sv
// sequenciador_uc: control unit for one sensor-measure / serial-TX / RX-load round.
// Optional per-byte receive timeout is built in when SEQUENCIADOR_RX_TIMEOUT_EN is defined.
module sequenciador_uc #(
   parameter int N_SENSORS        = 3,
   parameter int BYTES_PER_SENSOR = 4,
   parameter int N_RX             = 3,
   parameter int WAIT_CYCLES      = 50_000_000,
   parameter int TIMEOUT_CYCLES   = 100_000_000,
   localparam int SW = (N_SENSORS > 1) ? $clog2(N_SENSORS) : 1,
   localparam int BW = (BYTES_PER_SENSOR > 1) ? $clog2(BYTES_PER_SENSOR) : 1
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            jogar,
   input  logic            pronto_serial,
   input  logic            pronto_recepcao,
   output logic            medir,
   output logic            partida_tx,
   output logic [SW-1:0]   sel_sensor,
   output logic [BW-1:0]   sel_byte,
   output logic [N_RX-1:0] carrega_reg,
   output logic            zera_dp,
   output logic            pronto,
   output logic            timeout,
   output logic [3:0]      db_estado
);

   localparam int WW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
   localparam int RW = (N_RX > 1) ? $clog2(N_RX) : 1;

   if (N_SENSORS < 1 || BYTES_PER_SENSOR < 1 || N_RX < 1 || WAIT_CYCLES < 1 || TIMEOUT_CYCLES < 2)
   begin : g_param_check
      $error("sequenciador_uc: illegal parameter value");
   end

   typedef enum logic [3:0] {
      INICIAL      = 4'd0,
      ZERA         = 4'd1,
      MEDIR        = 4'd2,
      ESPERA       = 4'd3,
      ENVIA        = 4'd4,
      PROX_ENVIO   = 4'd5,
      ESPERA_RECEP = 4'd6,
      PROX_RECEP   = 4'd7,
      FINAL        = 4'd8,
      ERRO         = 4'd9
   } estado_t;

   estado_t         r_estado, w_prox_estado;
   logic [WW-1:0]   r_cnt_wait;
   logic [SW-1:0]   r_sel_sensor;
   logic [BW-1:0]   r_sel_byte;
   logic [RW-1:0]   r_cnt_rx;
   logic [N_RX-1:0] r_carrega, w_carrega;
   logic            r_medir, r_partida, r_zera_dp, r_pronto;
   logic            w_fim_espera, w_ultimo_byte, w_ultimo_sensor, w_ultimo_rx, w_estouro;

   assign w_fim_espera    = (r_cnt_wait == WW'(WAIT_CYCLES - 1));
   assign w_ultimo_byte   = (r_sel_byte == BW'(BYTES_PER_SENSOR - 1));
   assign w_ultimo_sensor = (r_sel_sensor == SW'(N_SENSORS - 1));
   assign w_ultimo_rx     = (r_cnt_rx == RW'(N_RX - 1));

`ifdef SEQUENCIADOR_RX_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES);
   logic [TW-1:0] r_cnt_to;
   logic          r_timeout;

   // Restarts on every entry to ESPERA_RECEP because it is held at zero everywhere else.
   always_ff @(posedge clock or posedge reset) begin
      if (reset)                          r_cnt_to <= '0;
      else if (r_estado == ESPERA_RECEP) r_cnt_to <= r_cnt_to + 1'b1;
      else                                r_cnt_to <= '0;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) r_timeout <= 1'b0;
      else       r_timeout <= (w_prox_estado == ERRO);
   end

   assign w_estouro = (r_cnt_to == TW'(TIMEOUT_CYCLES - 1));
   assign timeout   = r_timeout;
`else
   assign w_estouro = 1'b0;
   assign timeout   = 1'b0;
`endif

   // NOTE: non-blocking assignments so every flop samples the values from before the edge.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) r_estado <= INICIAL;
      else       r_estado <= w_prox_estado;
   end

   always_comb begin
      // NOTE: default assigned first so no path leaves the signal unassigned (no latch).
      w_prox_estado = r_estado;
      case (r_estado)
         INICIAL:      if (jogar) w_prox_estado = ZERA;
         ZERA:         w_prox_estado = MEDIR;
         MEDIR:        w_prox_estado = ESPERA;
         ESPERA:       if (w_fim_espera) w_prox_estado = ENVIA;
         ENVIA:        if (pronto_serial) w_prox_estado = PROX_ENVIO;
         PROX_ENVIO:   w_prox_estado = (w_ultimo_byte && w_ultimo_sensor) ? ESPERA_RECEP : ENVIA;
         ESPERA_RECEP: begin
            if (pronto_recepcao) w_prox_estado = PROX_RECEP;
            else if (w_estouro)  w_prox_estado = ERRO;
         end
         PROX_RECEP:   w_prox_estado = w_ultimo_rx ? FINAL : ESPERA_RECEP;
         FINAL:        w_prox_estado = INICIAL;
         ERRO:         w_prox_estado = INICIAL;
         default:      w_prox_estado = INICIAL;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_cnt_wait   <= '0;
         r_sel_sensor <= '0;
         r_sel_byte   <= '0;
         r_cnt_rx     <= '0;
      end else begin
         case (r_estado)
            ZERA: begin
               r_cnt_wait   <= '0;
               r_sel_sensor <= '0;
               r_sel_byte   <= '0;
               r_cnt_rx     <= '0;
            end
            ESPERA:     r_cnt_wait <= w_fim_espera ? '0 : r_cnt_wait + 1'b1;
            PROX_ENVIO: begin
               if (w_ultimo_byte) begin
                  r_sel_byte   <= '0;
                  r_sel_sensor <= w_ultimo_sensor ? '0 : r_sel_sensor + 1'b1;
               end else begin
                  r_sel_byte   <= r_sel_byte + 1'b1;
               end
            end
            PROX_RECEP: if (!w_ultimo_rx) r_cnt_rx <= r_cnt_rx + 1'b1;
            default: ;
         endcase
      end
   end

   // Pulse outputs are registered from the next state so they line up with it and cannot glitch.
   always_comb begin
      w_carrega = '0;
      if (w_prox_estado == PROX_RECEP) w_carrega = N_RX'(1) << r_cnt_rx;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_medir   <= 1'b0;
         r_partida <= 1'b0;
         r_zera_dp <= 1'b0;
         r_pronto  <= 1'b0;
         r_carrega <= '0;
      end else begin
         r_medir   <= (w_prox_estado == MEDIR);
         r_partida <= (w_prox_estado == ENVIA);
         r_zera_dp <= (w_prox_estado == ZERA) || (w_prox_estado == ERRO);
         r_pronto  <= (w_prox_estado == FINAL);
         r_carrega <= w_carrega;
      end
   end

   assign medir       = r_medir;
   assign partida_tx  = r_partida;
   assign zera_dp     = r_zera_dp;
   assign pronto      = r_pronto;
   assign carrega_reg = r_carrega;
   assign sel_sensor  = r_sel_sensor;
   assign sel_byte    = r_sel_byte;
   assign db_estado   = (r_estado > ERRO) ? 4'hF : r_estado;

endmodule

// File: tb/tb_sequenciador_uc.sv
// Scoreboard bench for sequenciador_uc: stimulus queues the expected TX order, load
// enables and round completions; a negedge monitor pops and compares as the DUT emits them.
module tb_sequenciador_uc;

   localparam int NS = 2, NB = 4, NR = 3, WC = 5, TO = 20;
   localparam int DONE_PRONTO = 1, DONE_TIMEOUT = 2;

   logic          clock = 1'b0;
   logic          reset, jogar, pronto_serial, pronto_recepcao;
   logic          medir, partida_tx, zera_dp, pronto, timeout;
   logic [0:0]    sel_sensor;
   logic [1:0]    sel_byte;
   logic [NR-1:0] carrega_reg;
   logic [3:0]    db_estado;

   int checks = 0;
   int failures = 0;

   int            exp_tx[$];
   logic [NR-1:0] exp_ld[$];
   int            exp_done[$];
   logic          prev_tx = 1'b0;

   sequenciador_uc #(
      .N_SENSORS(NS), .BYTES_PER_SENSOR(NB), .N_RX(NR),
      .WAIT_CYCLES(WC), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clock(clock), .reset(reset), .jogar(jogar),
      .pronto_serial(pronto_serial), .pronto_recepcao(pronto_recepcao),
      .medir(medir), .partida_tx(partida_tx), .sel_sensor(sel_sensor),
      .sel_byte(sel_byte), .carrega_reg(carrega_reg), .zera_dp(zera_dp),
      .pronto(pronto), .timeout(timeout), .db_estado(db_estado)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic wait_state(input logic [3:0] st, input string name);
      int n = 0;
      while (db_estado !== st && n < 200) begin
         tick();
         n++;
      end
      check(name, db_estado, st);
   endtask

   // Monitor: compares every emitted transaction against the head of its queue.
   always @(negedge clock) begin
      if (!reset) begin
         if (partida_tx && !prev_tx) begin
            if (exp_tx.size() == 0) check("tx_unexpected", 1, 0);
            else begin
               check("tx_sel", {29'd0, sel_sensor, sel_byte}, exp_tx[0]);
               void'(exp_tx.pop_front());
            end
         end
         if (carrega_reg != '0) begin
            if (exp_ld.size() == 0) check("ld_unexpected", carrega_reg, 0);
            else begin
               check("ld_onehot", carrega_reg, exp_ld[0]);
               void'(exp_ld.pop_front());
            end
         end
         if (pronto || timeout) begin
            if (exp_done.size() == 0) check("done_unexpected", {pronto, timeout}, 0);
            else begin
               check("done_kind", pronto ? DONE_PRONTO : DONE_TIMEOUT, exp_done[0]);
               void'(exp_done.pop_front());
            end
            if (timeout) check("erro_zera", zera_dp, 1);
         end
      end
      prev_tx <= partida_tx;
   end

   // One round. tx_delay: cycles from partida_tx rise to pronto_serial; abort_at: TX byte
   // index at which reset is applied (-1 none); spurious: misplaced handshakes and jogar held
   // through TX; rx_mode: 0 normal, 1 no first pronto_recepcao, 2 first one on the last cycle.
   task automatic run_round(input int tx_delay, input int abort_at, input bit spurious,
                            input int rx_mode);
      int n, medir_n, zera_n;
      bit expect_timeout;
      expect_timeout = 1'b0;
`ifdef SEQUENCIADOR_RX_TIMEOUT_EN
      expect_timeout = (rx_mode == 1);
`endif
      for (int s = 0; s < NS; s++)
         for (int b = 0; b < NB; b++) exp_tx.push_back(s * 4 + b);
      if (expect_timeout) exp_done.push_back(DONE_TIMEOUT);
      else begin
         for (int k = 0; k < NR; k++) exp_ld.push_back(NR'(1 << k));
         exp_done.push_back(DONE_PRONTO);
      end

      jogar = 1'b1;
      tick();
      if (!spurious) jogar = 1'b0;
      n = 1; medir_n = 0; zera_n = 0;
      while (!partida_tx && n < 100) begin
         medir_n += int'(medir);
         zera_n  += int'(zera_dp);
         tick();
         n++;
      end
      check("start_latency", n, 3 + WC);
      check("medir_pulses", medir_n, 1);
      check("zera_pulses", zera_n, 1);

      for (int i = 0; i < NS * NB; i++) begin
         n = 0;
         while (!partida_tx && n < 100) begin
            tick();
            n++;
         end
         if (!partida_tx) begin
            check("tx_wait", 0, 1);
            jogar = 1'b0;
            return;
         end
         if (i == abort_at) begin
            tick();
            reset = 1'b1;
            #1;
            check("abort_outputs", {medir, partida_tx, zera_dp, pronto, timeout,
                                    sel_sensor, sel_byte, carrega_reg, db_estado}, 0);
            exp_tx.delete(); exp_ld.delete(); exp_done.delete();
            tick();
            check("abort_state", db_estado, 0);
            reset = 1'b0;
            jogar = 1'b0;
            return;
         end
         pronto_recepcao = spurious;
         for (int d = 0; d < tx_delay; d++) begin
            tick();
            pronto_recepcao = 1'b0;
         end
         pronto_serial = 1'b1;
         tick();
         pronto_serial = 1'b0;
         pronto_recepcao = 1'b0;
         check("tx_release", partida_tx, 0);
         tick();
         if (i < NS * NB - 1) check("tx_next", partida_tx, 1);
         else                 check("rx_enter", db_estado, 6);
      end
      jogar = 1'b0;

      for (int k = 0; k < NR; k++) begin
         wait_state(4'd6, "rx_wait");
         if (rx_mode == 1 && k == 0) begin
            if (expect_timeout) begin
               n = 0;
               while (db_estado == 4'd6 && n < 100) begin
                  tick();
                  n++;
               end
               check("timeout_latency", n, TO);
               check("erro_pulse", {timeout, zera_dp, pronto}, 3'b110);
               tick();
               check("erro_end", {db_estado, timeout, zera_dp, pronto}, 0);
               return;
            end else begin
               repeat (3 * TO) tick();
               check("rx_waits", {timeout, db_estado}, 6);
            end
         end
         if (rx_mode == 2 && k == 0) repeat (TO - 1) tick();
         else begin
            pronto_serial = spurious;
            repeat ($urandom_range(0, 3)) begin
               tick();
               pronto_serial = 1'b0;
            end
         end
         pronto_recepcao = 1'b1;
         tick();
         pronto_recepcao = 1'b0;
         pronto_serial = 1'b0;
         check("rx_load_state", {timeout, db_estado}, 7);
      end

      n = 0;
      while (!pronto && n < 10) begin
         tick();
         n++;
      end
      check("pronto_latency", n, 1);
      tick();
      check("round_idle", {db_estado, pronto}, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      reset = 1'b1;
      jogar = 1'b0;
      pronto_serial = 1'b0;
      pronto_recepcao = 1'b0;
      repeat (3) tick();
      check("reset_outputs", {medir, partida_tx, zera_dp, pronto, timeout,
                              sel_sensor, sel_byte, carrega_reg, db_estado}, 0);
      reset = 1'b0;
      tick();
      check("idle_after_reset", db_estado, 0);

      run_round(2, -1, 1'b0, 0);
      run_round(0, -1, 1'b1, 0);
      run_round(2, 6, 1'b0, 0);
      run_round(2, -1, 1'b0, 0);
      run_round(1, -1, 1'b0, 1);
      run_round(3, -1, 1'b0, 2);
      for (int r = 0; r < 6; r++)
         run_round(int'($urandom_range(0, 3)), -1, 1'($urandom_range(0, 1)), 0);

      repeat (3) tick();
      check("scoreboard_drain", exp_tx.size() + exp_ld.size() + exp_done.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
